// File: rtl/id_token_stats.sv
// Splits a character stream into alphanumeric tokens and keeps statistics on those
// that the upstream identifier FSM flagged as valid when the token ended.
module id_token_stats #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [7:0]       char,
  input  logic             id_ok,
  output logic             id_done,
  output logic [CNT_W-1:0] id_count,
  output logic [LEN_W-1:0] last_len,
  output logic [LEN_W-1:0] max_len,
  output logic             in_token
);

  localparam logic GAP   = 1'b0;
  localparam logic TOKEN = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic             state_q, state_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] last_q, last_d;
  logic [LEN_W-1:0] max_q, max_d;
  logic             is_alnum;

  assign is_alnum = ((char >= 8'h30) && (char <= 8'h39)) ||
                    ((char >= 8'h41) && (char <= 8'h5A)) ||
                    ((char >= 8'h61) && (char <= 8'h7A));

  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    done_d    = 1'b0;
    count_d   = count_q;
    last_d    = last_q;
    max_d     = max_q;
    if (clr) begin
      state_d   = GAP;
      run_len_d = '0;
      count_d   = '0;
      last_d    = '0;
      max_d     = '0;
    end else begin
      case (state_q)
        GAP: begin
          if (is_alnum) begin
            state_d   = TOKEN;
            run_len_d = {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          if (is_alnum) begin
            run_len_d = (run_len_q == LEN_MAX) ? run_len_q : run_len_q + 1'b1;
          end else begin
            state_d   = GAP;
            run_len_d = '0;
            // id_ok only matters here, where a token is closed by a delimiter
            if (id_ok) begin
              done_d  = 1'b1;
              count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
              last_d  = run_len_q;
              max_d   = (run_len_q > max_q) ? run_len_q : max_q;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= GAP;
      run_len_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
      last_q    <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      done_q    <= done_d;
      count_q   <= count_d;
      last_q    <= last_d;
      max_q     <= max_d;
    end
  end

  assign id_done  = done_q;
  assign id_count = count_q;
  assign last_len = last_q;
  assign max_len  = max_q;
  assign in_token = (state_q == TOKEN);

endmodule

// File: tb/tb_id_token_stats.sv
// Bench for id_token_stats: two instances (wide and narrow counters) share one stream
// and are compared against a token-level reference model.
module tb_id_token_stats;

  localparam int CNT_A = 16;
  localparam int LEN_A = 8;
  localparam int CNT_B = 2;
  localparam int LEN_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic [7:0] ch = 8'h20;
  logic id_ok = 1'b0;

  logic             done_a, tok_a;
  logic [CNT_A-1:0] cnt_a;
  logic [LEN_A-1:0] last_a, max_a;
  logic             done_b, tok_b;
  logic [CNT_B-1:0] cnt_b;
  logic [LEN_B-1:0] last_b, max_b;

  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  // reference model: unbounded run length, clipped only when recorded
  int m_run;
  bit m_done;
  int m_cnt[2];
  int m_last[2];
  int m_max[2];
  int cmax[2];
  int lmax[2];

  always #5 clk = ~clk;

  id_token_stats #(.CNT_W(CNT_A), .LEN_W(LEN_A)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .char(ch), .id_ok(id_ok),
    .id_done(done_a), .id_count(cnt_a), .last_len(last_a), .max_len(max_a), .in_token(tok_a)
  );

  id_token_stats #(.CNT_W(CNT_B), .LEN_W(LEN_B)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .char(ch), .id_ok(id_ok),
    .id_done(done_b), .id_count(cnt_b), .last_len(last_b), .max_len(max_b), .in_token(tok_b)
  );

  function automatic bit alnum(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
  endfunction

  task automatic m_clear();
    m_run = 0;
    m_done = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_last[k] = 0;
      m_max[k] = 0;
    end
  endtask

  task automatic m_edge(input logic [7:0] c, input logic ok, input logic cl);
    int l;
    if (cl) begin
      m_clear();
    end else if (alnum(c)) begin
      m_run++;
      m_done = 0;
    end else begin
      m_done = (m_run > 0) && ok;
      if (m_done) begin
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] = (m_cnt[k] + 1 > cmax[k]) ? cmax[k] : m_cnt[k] + 1;
          l = (m_run > lmax[k]) ? lmax[k] : m_run;
          m_last[k] = l;
          if (l > m_max[k]) m_max[k] = l;
        end
      end
      m_run = 0;
    end
  endtask

  // drive one character across one active edge; returns at the following negedge
  task automatic step(input logic [7:0] c, input logic ok, input logic cl);
    ch = c;
    id_ok = ok;
    clr = cl;
    @(posedge clk);
    m_edge(c, ok, cl);
    @(negedge clk);
    clr = 1'b0;
    if (done_a) pulses_a++;
    if (done_b) pulses_b++;
  endtask

  task automatic send_str(input string s, input logic ok);
    for (int i = 0; i < s.len(); i++) step(s[i], ok, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    m_clear();
    #1;
    reset = 1'b0;
    pulses_a = 0;
    pulses_b = 0;
  endtask

  task automatic test_reset();
    async_reset();
    checks++;
    if ({done_a, cnt_a, last_a, max_a, tok_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got %0b/%0d/%0d/%0d/%0b want all 0", done_a, cnt_a, last_a, max_a, tok_a);
    end
    checks++;
    if ({done_b, cnt_b, last_b, max_b, tok_b} !== '0) begin
      errors++;
      $display("FAIL reset_b got %0b/%0d/%0d/%0d/%0b want all 0", done_b, cnt_b, last_b, max_b, tok_b);
    end
  endtask

  task automatic test_basic();
    async_reset();
    send_str("ab12", 1'b1);
    checks++;
    if (tok_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_in_token got tok=%0b done=%0b want tok=1 done=0", tok_a, done_a);
    end
    step(";", 1'b1, 1'b0);
    checks++;
    if ({done_a, cnt_a, last_a, max_a, tok_a} !== {1'b1, 16'd1, 8'd4, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic_done got %0b/%0d/%0d/%0d/%0b want 1/1/4/4/0", done_a, cnt_a, last_a, max_a, tok_a);
    end
    step(";", 1'b1, 1'b0);
    checks++;
    if (done_a !== 1'b0 || cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL basic_one_pulse got done=%0b cnt=%0d want done=0 cnt=1", done_a, cnt_a);
    end
  endtask

  task automatic test_rejected();
    async_reset();
    send_str("a1 ", 1'b1);
    send_str("abc ", 1'b0);
    send_str("9 ;", 1'b0);
    checks++;
    if (pulses_a !== 1 || cnt_a !== 16'd1 || last_a !== 8'd2 || max_a !== 8'd2) begin
      errors++;
      $display("FAIL rejected got pulses=%0d cnt=%0d last=%0d max=%0d want 1/1/2/2", pulses_a, cnt_a, last_a, max_a);
    end
  endtask

  task automatic test_back_to_back();
    async_reset();
    send_str("x9,yyy77,z1.", 1'b1);
    checks++;
    if (pulses_a !== 3 || cnt_a !== 16'd3 || last_a !== 8'd2 || max_a !== 8'd5) begin
      errors++;
      $display("FAIL three_tokens got pulses=%0d cnt=%0d last=%0d max=%0d want 3/3/2/5", pulses_a, cnt_a, last_a, max_a);
    end
    // digit-led token accepted by the FSM keeps its full length; NUL is a delimiter
    send_str("1a2", 1'b1);
    step(8'h00, 1'b1, 1'b0);
    checks++;
    if (done_a !== 1'b1 || cnt_a !== 16'd4 || last_a !== 8'd3 || max_a !== 8'd5) begin
      errors++;
      $display("FAIL digit_led got done=%0b cnt=%0d last=%0d max=%0d want 1/4/3/5", done_a, cnt_a, last_a, max_a);
    end
  endtask

  task automatic test_len_saturate();
    async_reset();
    for (int i = 0; i < 300; i++) step("a", 1'b1, 1'b0);
    send_str("1 ", 1'b1);
    checks++;
    if (cnt_a !== 16'd1 || last_a !== 8'd255 || max_a !== 8'd255) begin
      errors++;
      $display("FAIL len_sat_a got cnt=%0d last=%0d max=%0d want 1/255/255", cnt_a, last_a, max_a);
    end
    checks++;
    if (cnt_b !== 2'd1 || last_b !== 3'd7 || max_b !== 3'd7) begin
      errors++;
      $display("FAIL len_sat_b got cnt=%0d last=%0d max=%0d want 1/7/7", cnt_b, last_b, max_b);
    end
  endtask

  task automatic test_reset_mid_token();
    async_reset();
    send_str("ab1", 1'b1);
    async_reset();
    step(" ", 1'b1, 1'b0);
    checks++;
    if (pulses_a !== 0 || cnt_a !== 16'd0 || tok_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got pulses=%0d cnt=%0d tok=%0b want 0/0/0", pulses_a, cnt_a, tok_a);
    end
    send_str("q7;", 1'b1);
    checks++;
    if (cnt_a !== 16'd1 || last_a !== 8'd2) begin
      errors++;
      $display("FAIL pre_clr got cnt=%0d last=%0d want 1/2", cnt_a, last_a);
    end
    send_str("zz", 1'b1);
    step("w", 1'b1, 1'b1);
    checks++;
    if ({done_a, cnt_a, last_a, max_a, tok_a} !== '0) begin
      errors++;
      $display("FAIL clr got %0b/%0d/%0d/%0d/%0b want all 0", done_a, cnt_a, last_a, max_a, tok_a);
    end
    step(" ", 1'b1, 1'b0);
    checks++;
    if (done_a !== 1'b0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL clr_discard got done=%0b cnt=%0d want 0/0", done_a, cnt_a);
    end
  endtask

  task automatic test_cnt_saturate();
    async_reset();
    for (int i = 0; i < 5; i++) send_str("k1 ", 1'b1);
    checks++;
    if (pulses_b !== 5 || cnt_b !== 2'd3) begin
      errors++;
      $display("FAIL cnt_sat_b got pulses=%0d cnt=%0d want 5/3", pulses_b, cnt_b);
    end
    checks++;
    if (cnt_a !== 16'd5) begin
      errors++;
      $display("FAIL cnt_a got %0d want 5", cnt_a);
    end
  endtask

  task automatic test_random();
    logic [7:0] delims[10] = '{8'h00, 8'h20, 8'h3B, 8'hFF, 8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h60, 8'h7B};
    logic [7:0] c;
    logic ok, cl;
    int sel;
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        case ($urandom_range(0, 2))
          0: c = 8'($urandom_range(48, 57));
          1: c = 8'($urandom_range(65, 90));
          default: c = 8'($urandom_range(97, 122));
        endcase
        if ($urandom_range(0, 3) == 0) c = (sel < 3) ? "a" : "Z";
      end else begin
        c = delims[$urandom_range(0, 9)];
      end
      ok = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      step(c, ok, cl);
      checks++;
      if ({done_a, cnt_a, last_a, max_a, tok_a} !==
          {m_done, CNT_A'(m_cnt[0]), LEN_A'(m_last[0]), LEN_A'(m_max[0]), (m_run > 0)}) begin
        errors++;
        $display("FAIL random_a n=%0d got %0b/%0d/%0d/%0d/%0b want %0b/%0d/%0d/%0d/%0b", n,
                 done_a, cnt_a, last_a, max_a, tok_a, m_done, m_cnt[0], m_last[0], m_max[0], m_run > 0);
      end
      checks++;
      if ({done_b, cnt_b, last_b, max_b, tok_b} !==
          {m_done, CNT_B'(m_cnt[1]), LEN_B'(m_last[1]), LEN_B'(m_max[1]), (m_run > 0)}) begin
        errors++;
        $display("FAIL random_b n=%0d got %0b/%0d/%0d/%0d/%0b want %0b/%0d/%0d/%0d/%0b", n,
                 done_b, cnt_b, last_b, max_b, tok_b, m_done, m_cnt[1], m_last[1], m_max[1], m_run > 0);
      end
    end
  endtask

  initial begin
    cmax[0] = (1 << CNT_A) - 1;
    cmax[1] = (1 << CNT_B) - 1;
    lmax[0] = (1 << LEN_A) - 1;
    lmax[1] = (1 << LEN_B) - 1;
    m_clear();
    test_reset();
    test_basic();
    test_rejected();
    test_back_to_back();
    test_len_saturate();
    test_reset_mid_token();
    test_cnt_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
